// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a valid/ready load
// handshake. A WIDTH-bit word is shifted out one bit per clock on `out`,
// qualified by `frame`. `done` marks the last bit of each word. Back-to-back
// words stream without a gap because a new word can be accepted while the
// last bit of the current one is on the line.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             frame,
  output logic             done
);

  // Counter needs at least one bit even for the smallest legal word.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_LAST_M1 = CW'(WIDTH - 2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             out_q;
  logic             frame_q;
  logic             done_q;
  logic             accept_s;

  // Bit that sits at the output end of a word for the chosen bit order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Move the word one place toward the output end, zero-filling behind it.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // Ready when idle, or when the last bit of the current word is on the line.
  always_comb begin
    load_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_LAST));
    accept_s   = load_valid && load_ready;
  end

  // Transmit FSM: loads words, shifts bits out and drives the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q <= SHIFT;
            sh_q    <= din;
            cnt_q   <= '0;
            out_q   <= first_bit(din);
            frame_q <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt_q != CNT_LAST) begin
            // Mid-word: present the next bit; flag the last one with done.
            state_q <= SHIFT;
            cnt_q   <= cnt_q + CW'(1);
            sh_q    <= shift_word(sh_q);
            out_q   <= first_bit(shift_word(sh_q));
            frame_q <= 1'b1;
            done_q  <= (cnt_q == CNT_LAST_M1);
          end else if (accept_s) begin
            // Last bit on the line and a new word waiting: chain it directly.
            state_q <= SHIFT;
            sh_q    <= din;
            cnt_q   <= '0;
            out_q   <= first_bit(din);
            frame_q <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          sh_q    <= '0;
          cnt_q   <= '0;
          out_q   <= 1'b0;
          frame_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out   = out_q;
  assign frame = frame_q;
  assign done  = done_q;

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter with a valid/ready load handshake. It accepts a WIDTH-bit word and shifts it out one bit per clock on a single serial line, with a frame qualifier marking valid bits. It is the transmit end for the team's serial-in shift-register chains: its out/frame pair drives the d input of a SISO or SIPO receiver. Back-to-back words stream without gaps.

## Interface

- WIDTH, default 4: word length in bits; legal range 2..32.
- MSB_FIRST, default 1: 1 transmits din[WIDTH-1] first; 0 transmits din[0] first.

- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- din, input, WIDTH: parallel word; sampled only on an accepted load.
- load_valid, input, 1: upstream has a word on din.
- load_ready, output, 1: block can accept a word this cycle; combinational from state and counter.
- out, output, 1: serial data; registered.
- frame, output, 1: out carries a valid bit this cycle; registered.
- done, output, 1: one-cycle pulse coincident with the last bit of a word; registered.

## Operation

- State: shift register sh[WIDTH-1:0], bit counter cnt (width clog2(WIDTH), minimum 1), FSM {IDLE, SHIFT}.
- Reset (async, rst_n low): state=IDLE, sh=0, cnt=0, out=0, frame=0, done=0. load_ready reads 1 as soon as rst_n is high again.
- Accept: load_valid && load_ready at a rising edge. Otherwise din is ignored; a changing din never affects a word in flight.
- load_ready = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1).
- IDLE + accept -> SHIFT:
  - sh loads din;
  - out = first bit (din[WIDTH-1] if MSB_FIRST, else din[0]);
  - frame=1, cnt=0, done=0.
- SHIFT, cnt<WIDTH-1:
  - cnt increments;
  - sh shifts toward the output end (left if MSB_FIRST, right otherwise), zero-filling;
  - out = next bit; frame stays 1;
  - done=1 on the edge that presents bit WIDTH-1, else 0.
- SHIFT, cnt==WIDTH-1 (last bit on out), with accept:
  - stay in SHIFT; load din as in IDLE accept;
  - out = new word's first bit; frame stays 1; done=0.
- SHIFT, cnt==WIDTH-1, no accept -> IDLE: out=0, frame=0, done=0.
- IDLE, no accept: all outputs hold reset values.
- out is 0 whenever frame is 0.

## Timing

- Latency: a word accepted at edge N puts bit 0 (first transmitted) on out after edge N, bit k after edge N+k, and the last bit after edge N+WIDTH-1.
- frame is high for exactly WIDTH cycles per word.
- done is high only during the cycle showing the last bit.
- Throughput: one word per WIDTH cycles. Back-to-back accepts at edges N and N+WIDTH give a contiguous 2·WIDTH-bit frame with no deasserted cycle.
- Between words, load_ready is low for WIDTH-1 consecutive cycles. load_valid during those cycles is not accepted, and upstream must hold the word.
- Reset mid-word: outputs clear immediately and asynchronously, without waiting for a clock edge. The partial word is discarded, not resumed, and no done is produced.
- Simultaneous reset release and load_valid: no accept before the first rising edge with rst_n high.

## Test plan

- Reset: rst_n=0 with load_valid=1 and din=4'hF -> out=0, frame=0, done=0, no shifting. After release, load_ready=1.
- Single word, WIDTH=4, MSB_FIRST=1, din=4'b1011 accepted at edge N -> out=1,0,1,1 after edges N..N+3. frame=1 for those 4 cycles, done=1 only in the 4th, then out=0 and frame=0.
- Same word with MSB_FIRST=0 -> out=1,1,0,1.
- Back-to-back 4'hA then 4'h5, load_valid held high -> out=1,0,1,0,0,1,0,1. frame continuous for 8 cycles, done pulses at bit 4 and bit 8. load_ready=1 only at the accept cycles.
- Busy hold: during 4'hC transmission, toggle din each cycle with load_valid=1 -> out=1,1,0,0 unchanged. Next word accepted only when cnt==3.
- Reset mid-word: assert rst_n=0 after the 2nd bit of 4'b1001 -> out and frame drop to 0 before the next edge, no done. After release, a new word 4'b0110 transmits correctly.
